display_arbiter: RTL

Time-shares the 4-digit multiplexed seven-segment display between three requesters: background game data, the character/menu screens and short alert messages. Each requester presents a full 4-digit frame. The block grants one requester at a time by fixed priority, enforces a minimum on-screen hold time, and optionally blinks the granted frame. Its digit outputs feed the display scanner's four per-digit segment inputs.

---
 rtl/display_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// display_arbiter
// Time-shares the 4-digit seven-segment display between three requesters
// (bit 2 = alerts, highest priority; bit 0 = background, lowest). One owner
// at a time holds the screen for a minimum number of ticks; after that the
// owner can be preempted by a higher request or released when it drops req.
// The owner's frame can optionally blink.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   req[2:0]       per-requester request, bit 2 highest priority
//   frame0..2      per-requester 4-digit frame, [6:0]=digit0 .. [27:21]=digit3
//   blink[2:0]     per-requester blink enable, used live while granted
//   grant[2:0]     one-hot current owner, 0 when idle
//   busy           grant != 0
//   done           one-cycle pulse on the cycle a grant ends or moves
//   digit0..3      segment patterns to the scanner, 0 = blank
module display_arbiter #(
  parameter int TICK_DIV    = 27000,
  parameter int HOLD_TICKS  = 1500,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [27:0] frame0,
  input  logic [27:0] frame1,
  input  logic [27:0] frame2,
  input  logic [2:0]  blink,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        done,
  output logic [6:0]  digit0,
  output logic [6:0]  digit1,
  output logic [6:0]  digit2,
  output logic [6:0]  digit3
);

  localparam int TCNT_W = $clog2(TICK_DIV + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int BLNK_W = $clog2(BLINK_TICKS + 1);

  localparam logic [TCNT_W-1:0] TICK_LAST  = TCNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_TICKS);
  localparam logic [BLNK_W-1:0] BLINK_LAST = BLNK_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_OPEN} state_t;

  state_t              state, state_nxt;
  logic [TCNT_W-1:0]   tick_cnt;
  logic                tick;
  logic [HOLD_W-1:0]   hold_cnt, hold_dec;
  logic [BLNK_W-1:0]   blink_cnt;
  logic                blink_hide;
  logic [2:0]          grant_nxt;
  logic                new_grant;
  logic                done_nxt;
  logic [27:0]         frame_p1;
  logic                show;

  // One-hot of the highest set request bit.
  function automatic logic [2:0] highest(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  // Request bits that outrank the one-hot owner g.
  function automatic logic [2:0] higher_mask(input logic [2:0] g);
    return {g[1] | g[0], g[0], 1'b0};
  endfunction

  function automatic logic [27:0] frame_sel(input logic [2:0] g,
                                            input logic [27:0] f0,
                                            input logic [27:0] f1,
                                            input logic [27:0] f2);
    unique case (g)
      3'b100:  return f2;
      3'b010:  return f1;
      3'b001:  return f0;
      default: return 28'd0;
    endcase
  endfunction

  assign tick     = (tick_cnt == TICK_LAST);
  assign hold_dec = (tick && hold_cnt != '0) ? hold_cnt - HOLD_W'(1) : hold_cnt;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    new_grant = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req) begin
          grant_nxt = highest(req);
          new_grant = 1'b1;
          state_nxt = S_LOCKED;
        end
      end
      // Leave LOCKED on the same edge the last hold tick lands, so OPEN
      // arbitrates on the very next cycle.
      S_LOCKED: begin
        if (hold_dec == '0) state_nxt = S_OPEN;
      end
      // Preemption and release both hand the screen to the highest pending
      // request; preemption wins even if the owner drops req in that cycle.
      S_OPEN: begin
        if ((|(req & higher_mask(grant))) || !(|(req & grant))) begin
          if (|req) begin
            grant_nxt = highest(req);
            new_grant = 1'b1;
            state_nxt = S_LOCKED;
          end else begin
            grant_nxt = 3'b000;
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        grant_nxt = 3'b000;
        state_nxt = S_IDLE;
      end
    endcase
    done_nxt = (|grant) && (grant_nxt != grant);
  end

  // Stage p0 -> p1: control state, counters and grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= 3'b000;
      done       <= 1'b0;
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      tick_cnt <= tick ? '0 : tick_cnt + TCNT_W'(1);
      // A tick on the grant edge is ignored by the freshly loaded counters.
      if (new_grant) begin
        hold_cnt   <= HOLD_LOAD;
        blink_cnt  <= '0;
        blink_hide <= 1'b0;
      end else begin
        hold_cnt <= hold_dec;
        if (tick && (|grant)) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt  <= '0;
            blink_hide <= ~blink_hide;
          end else begin
            blink_cnt <= blink_cnt + BLNK_W'(1);
          end
        end
      end
    end
  end

  // Stage p0 -> p1: latched frame; only meaningful while grant != 0
  always_ff @(posedge clk) begin
    if (new_grant)
      frame_p1 <= frame_sel(grant_nxt, frame0, frame1, frame2);
    else if (|(req & grant))
      frame_p1 <= frame_sel(grant, frame0, frame1, frame2);
  end

  // blink is used live so clearing it un-blanks immediately.
  assign show   = (|grant) && !((|(blink & grant)) && blink_hide);
  assign busy   = |grant;
  assign digit0 = show ? frame_p1[6:0]   : 7'd0;
  assign digit1 = show ? frame_p1[13:7]  : 7'd0;
  assign digit2 = show ? frame_p1[20:14] : 7'd0;
  assign digit3 = show ? frame_p1[27:21] : 7'd0;

endmodule
